// File: rtl/sdram_line_fetch_module.sv
// sdram_line_fetch_module
//   Fetches one pixel line from SDRAM whenever the VGA block requests a new
//   line tag, issuing fixed-length read bursts and streaming the returned
//   words into the line RAM write port. Tag changes that arrive during a
//   fetch are coalesced so that only the newest one is fetched next.
//
// Ports
//   clk       100 MHz SDRAM-domain clock, rising edge
//   rst_n     asynchronous active-low reset
//   iTag      requested line index; a change requests a fetch
//   oRdReq    burst read request, held until iRdAck
//   oAddr     burst start word address, stable while oRdReq=1
//   iRdAck    one-cycle acceptance of the current request
//   iRdValid  read data beat valid
//   iRdData   read data beat
//   oEn       line RAM write strobe
//   oData     line RAM write data
//   oBusy     fetch in progress
//   oDone     one-cycle pulse together with the last write of a line
//   oErr      sticky: a data beat arrived outside the data phase
module sdram_line_fetch_module #(
  parameter int unsigned LINE_WORDS = 640,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned ADDR_W     = 22,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [10:0]       iTag,
  output logic              oRdReq,
  output logic [ADDR_W-1:0] oAddr,
  input  logic              iRdAck,
  input  logic              iRdValid,
  input  logic [15:0]       iRdData,
  output logic              oEn,
  output logic [15:0]       oData,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr
);

  localparam int unsigned WCW = $clog2(LINE_WORDS + 1);
  localparam int unsigned BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DATA
  } state_t;

  state_t           state_q, state_d;
  logic [10:0]      tag_q;
  logic [10:0]      last_tag_q, last_tag_d;
  logic [10:0]      req_tag_q, req_tag_d;
  logic [10:0]      line_q, line_d;
  logic             pending_q, pending_d;
  logic [WCW-1:0]   word_cnt_q, word_cnt_d;
  logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
  logic             en_q, en_d;
  logic [15:0]      data_q, data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             load;
  logic [ADDR_W-1:0] addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tag_q      <= '0;
      last_tag_q <= '0;
      req_tag_q  <= '0;
      line_q     <= '0;
      pending_q  <= 1'b0;
      word_cnt_q <= '0;
      beat_cnt_q <= '0;
      en_q       <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tag_q      <= iTag;
      last_tag_q <= last_tag_d;
      req_tag_q  <= req_tag_d;
      line_q     <= line_d;
      pending_q  <= pending_d;
      word_cnt_q <= word_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      en_q       <= en_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_tag_d = last_tag_q;
    req_tag_d  = req_tag_q;
    line_d     = line_q;
    pending_d  = pending_q;
    word_cnt_d = word_cnt_q;
    beat_cnt_d = beat_cnt_q;
    en_d       = 1'b0;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = err_q;
    load       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          load       = 1'b1;
          line_d     = req_tag_q;
          last_tag_d = req_tag_q;
          word_cnt_d = '0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (iRdAck) begin
          beat_cnt_d = '0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (iRdValid) begin
          en_d       = 1'b1;
          data_d     = iRdData;
          beat_cnt_d = beat_cnt_q + 1'b1;
          word_cnt_d = word_cnt_q + 1'b1;
          if (beat_cnt_q == BCW'(BURST_LEN - 1)) begin
            if (word_cnt_q == WCW'(LINE_WORDS - 1)) begin
              // done is registered alongside en so both appear on the final write
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_REQ;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (iRdValid && (state_q != S_DATA)) begin
      err_d = 1'b1;
    end

    // On a load the comparison is against the tag being loaded, so a change
    // landing in the same cycle is not lost.
    if (load) begin
      pending_d = (tag_q != req_tag_q);
      req_tag_d = tag_q;
    end else if (tag_q != last_tag_q) begin
      pending_d = 1'b1;
      req_tag_d = tag_q;
    end
  end

  assign addr = ADDR_W'(BASE_ADDR)
              + ADDR_W'(line_q) * ADDR_W'(LINE_WORDS)
              + ADDR_W'(word_cnt_q);

  assign oRdReq = (state_q == S_REQ);
  assign oAddr  = (state_q == S_REQ) ? addr : '0;
  assign oEn    = en_q;
  assign oData  = data_q;
  assign oBusy  = (state_q != S_IDLE);
  assign oDone  = done_q;
  assign oErr   = err_q;

endmodule

// File: tb/tb_sdram_line_fetch_module.sv
module tb_sdram_line_fetch_module;

  localparam int unsigned LW   = 640;
  localparam int unsigned BL   = 8;
  localparam int unsigned AW   = 22;
  localparam int unsigned BASE = 0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [10:0]   iTag;
  logic          oRdReq;
  logic [AW-1:0] oAddr;
  logic          iRdAck;
  logic          iRdValid;
  logic [15:0]   iRdData;
  logic          oEn;
  logic [15:0]   oData;
  logic          oBusy;
  logic          oDone;
  logic          oErr;

  always #5 clk = ~clk;

  sdram_line_fetch_module #(
    .LINE_WORDS(LW),
    .BURST_LEN (BL),
    .ADDR_W    (AW),
    .BASE_ADDR (BASE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .iTag    (iTag),
    .oRdReq  (oRdReq),
    .oAddr   (oAddr),
    .iRdAck  (iRdAck),
    .iRdValid(iRdValid),
    .iRdData (iRdData),
    .oEn     (oEn),
    .oData   (oData),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oErr    (oErr)
  );

  typedef struct {
    logic [15:0] data;
    int unsigned cyc;
  } wr_t;

  int            total = 0;
  int            bad = 0;
  int unsigned   cyc = 0;
  int            done_cnt = 0;
  int            line_wr = 0;
  logic [AW-1:0] exp_addr[$];
  wr_t           exp_wr[$];
  logic [AW-1:0] cur_exp = '0;
  logic          prev_req = 1'b0;

  int            rphase = 0;
  int            rwait = 0;
  int            rbeats = 0;
  logic          tog = 1'b0;
  int            ack_delay = 2;
  int            gap_mode = 0;
  bit            manual = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a requested line is fetched as LW/BL bursts at
  // consecutive addresses starting at BASE + line*LW.
  task automatic push_line(input int line);
    for (int k = 0; k < int'(LW / BL); k++) begin
      int unsigned a;
      a = (BASE + line * LW + k * BL) % (1 << AW);
      exp_addr.push_back(AW'(a));
    end
  endtask

  // SDRAM responder: acks after ack_delay cycles, then returns BL beats.
  always @(negedge clk) begin
    if (!rst_n) begin
      rphase   = 0;
      iRdAck   = 1'b0;
      iRdValid = 1'b0;
    end else if (!manual) begin
      iRdAck   = 1'b0;
      iRdValid = 1'b0;
      if (rphase == 0) begin
        if (oRdReq) begin
          rphase = 1;
          rwait  = ack_delay;
        end
      end else if (rphase == 1) begin
        if (rwait <= 1) begin
          iRdAck = 1'b1;
          rphase = 2;
          rbeats = 0;
          tog    = 1'b0;
        end else begin
          rwait--;
        end
      end else begin
        bit send;
        case (gap_mode)
          0:       send = 1'b1;
          1:       send = (tog == 1'b0);
          default: send = ($urandom_range(0, 1) == 1);
        endcase
        tog = ~tog;
        if (send) begin
          wr_t e;
          iRdValid = 1'b1;
          iRdData  = 16'($urandom);
          e.data   = iRdData;
          e.cyc    = cyc + 1;
          exp_wr.push_back(e);
          rbeats++;
          if (rbeats == int'(BL)) rphase = 0;
        end
      end
    end
  end

  // Monitor: compares requests and writes against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
      line_wr  = 0;
    end else begin
      if (oRdReq) begin
        if (!prev_req) begin
          if (exp_addr.size() == 0) begin
            total++;
            bad++;
            $display("FAIL req_unexpected got addr=%0d want no request", oAddr);
            cur_exp = '1;
          end else begin
            cur_exp = exp_addr.pop_front();
            chk("req_addr", 32'(oAddr), 32'(cur_exp));
          end
        end else begin
          chk("req_addr_stable", 32'(oAddr), 32'(cur_exp));
        end
      end
      prev_req = oRdReq;

      if (oEn) begin
        if (exp_wr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wr_unexpected got data=%0h want no write", oData);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_data", 32'(oData), 32'(e.data));
          chk("wr_latency", cyc, e.cyc);
          line_wr++;
          chk("done_pulse", 32'(oDone), 32'(line_wr == int'(LW)));
          if (line_wr == int'(LW)) begin
            line_wr = 0;
            done_cnt++;
          end
        end
      end else if (oDone) begin
        total++;
        bad++;
        $display("FAIL done_stray got oDone=1 want 0 without write");
      end
    end
  end

  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < 30000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_words(input int target, input string name);
    int n;
    n = 0;
    while (line_wr < target && n < 30000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, 32'(line_wr >= target), 32'd1);
  endtask

  task automatic line_end_checks(input string name);
    chk({name, "_req_left"}, 32'(exp_addr.size()), 32'd0);
    chk({name, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    @(negedge clk);
    #1;
    chk({name, "_busy_after"}, 32'(oBusy), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    iTag     = '0;
    iRdAck   = 1'b0;
    iRdValid = 1'b0;
    iRdData  = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdreq", 32'(oRdReq), 32'd0);
    chk("rst_addr", 32'(oAddr), 32'd0);
    chk("rst_en", 32'(oEn), 32'd0);
    chk("rst_data", 32'(oData), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_done", 32'(oDone), 32'd0);
    chk("rst_err", 32'(oErr), 32'd0);
    #1 rst_n = 1'b1;

    // Contiguous beats, line 5.
    @(negedge clk);
    #2;
    push_line(5);
    iTag = 11'd5;
    wait_done(1, "t1_done");
    line_end_checks("t1");

    // Beats on alternate cycles, line 9.
    gap_mode = 1;
    @(negedge clk);
    #2;
    push_line(9);
    iTag = 11'd9;
    wait_done(2, "t2_done");
    line_end_checks("t2");

    // Coalescing: 6 then 7 requested during line 5; only 7 follows.
    gap_mode = 2;
    @(negedge clk);
    #2;
    push_line(5);
    push_line(7);
    iTag = 11'd5;
    wait_words(100, "t3_mid");
    #1 iTag = 11'd6;
    repeat (3) @(negedge clk);
    #2 iTag = 11'd7;
    wait_done(3, "t3_done5");
    wait_done(4, "t3_done7");
    line_end_checks("t3");

    // Long ack stall on every request.
    gap_mode  = 0;
    ack_delay = 51;
    @(negedge clk);
    #2;
    push_line(1);
    iTag = 11'd1;
    wait_done(5, "t4_done");
    line_end_checks("t4");
    ack_delay = 2;

    // Stray beat while idle.
    chk("t5_err_before", 32'(oErr), 32'd0);
    @(negedge clk);
    #2;
    manual   = 1'b1;
    iRdValid = 1'b1;
    iRdData  = 16'h1234;
    @(negedge clk);
    #2 iRdValid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("t5_err_set", 32'(oErr), 32'd1);
    chk("t5_busy", 32'(oBusy), 32'd0);
    manual = 1'b0;
    @(negedge clk);
    #2;
    push_line(2);
    iTag = 11'd2;
    wait_done(6, "t5_done");
    chk("t5_err_sticky", 32'(oErr), 32'd1);
    line_end_checks("t5");

    // Reset in the middle of a line.
    gap_mode = 2;
    @(negedge clk);
    #2;
    push_line(3);
    iTag = 11'd3;
    wait_words(300, "t6_mid");
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rdreq", 32'(oRdReq), 32'd0);
    chk("t6_addr", 32'(oAddr), 32'd0);
    chk("t6_en", 32'(oEn), 32'd0);
    chk("t6_data", 32'(oData), 32'd0);
    chk("t6_busy", 32'(oBusy), 32'd0);
    chk("t6_done", 32'(oDone), 32'd0);
    chk("t6_err", 32'(oErr), 32'd0);
    manual = 1'b1;
    iTag   = '0;
    exp_addr.delete();
    exp_wr.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    iRdValid = 1'b0;
    iRdAck   = 1'b0;
    @(negedge clk);
    #2;
    iRdValid = 1'b1;
    iRdData  = 16'hBEEF;
    @(negedge clk);
    #2 iRdValid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("t6_late_err", 32'(oErr), 32'd1);
    manual   = 1'b0;
    gap_mode = 0;
    @(negedge clk);
    #2;
    push_line(4);
    iTag = 11'd4;
    wait_done(7, "t6_done");
    line_end_checks("t6");
    chk("final_err", 32'(oErr), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
